// File: rtl/gs232c_btb_pkg.sv
// Shared definitions for the banked BTB bitmap: default geometry, a
// constant log2 helper and the clear/run state encoding.
package gs232c_btb_pkg;

  localparam int AW_DEF    = 10;
  localparam int NB_DEF    = 4;
  localparam int SEG_W_DEF = 4;

  // Ceiling log2, usable in parameter expressions.
  function automatic int log2_ceil(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  localparam int ROWS_DEF = (2 ** AW_DEF) / NB_DEF;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_RUN   = 1'b1
  } state_e;

endpackage

// File: rtl/gs232c_bitmap_rot.sv
// NB-bit rotator. left=1 maps window lanes onto banks (lane i -> bank
// (i+amt)%NB); left=0 maps banks back onto window lanes.
module gs232c_bitmap_rot
  import gs232c_btb_pkg::*;
#(
  parameter int NB = NB_DEF,
  parameter int SW = log2_ceil(NB)
) (
  input  logic [NB-1:0] din,
  input  logic [SW-1:0] amt,
  input  logic          left,
  output logic [NB-1:0] dout
);

  // Modulo-NB index arithmetic relies on NB being a power of two.
  always_comb begin
    logic [SW-1:0] src;
    dout = '0;
    for (int i = 0; i < NB; i++) begin
      src     = left ? (SW'(i) - amt) : (SW'(i) + amt);
      dout[i] = din[src];
    end
  end

endmodule

// File: rtl/gs232c_btb_bitmap_banked.sv
// Banked BTB bitmap: NB interleaved single-bit banks serving one unaligned
// NB-bit window read and one masked window write per cycle, with a
// registered read, write-first bypass and a hardware clear sweep.
module gs232c_btb_bitmap_banked
  import gs232c_btb_pkg::*;
#(
  parameter int AW    = AW_DEF,
  parameter int NB    = NB_DEF,
  parameter int SEG_W = SEG_W_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          flush,
  output logic          ready,
  input  logic          rd_en,
  input  logic [AW-1:0] raddr,
  output logic          rvalid,
  output logic [NB-1:0] rdata,
  input  logic          wr_en,
  input  logic [AW-1:0] waddr,
  input  logic [NB-1:0] wmask,
  input  logic [NB-1:0] wdata
);

  localparam int LNB  = log2_ceil(NB);
  localparam int ROWS = (2 ** AW) / NB;
  localparam int RW   = AW - LNB;
  localparam int SP1  = SEG_W + 1;

  // Lanes whose bit would carry out of the window's segment are invalid.
  function automatic logic [NB-1:0] seg_lane_mask(input logic [AW-1:0] addr);
    logic [NB-1:0] m;
    logic [SEG_W:0] pos;
    for (int i = 0; i < NB; i++) begin
      pos  = {1'b0, addr[SEG_W-1:0]} + SP1'(i);
      m[i] = ~pos[SEG_W];
    end
    return m;
  endfunction

  // Banks below the start bank hold their lane one row further on.
  function automatic logic [RW-1:0] bank_row(input logic [AW-1:0] addr, input int b);
    return addr[AW-1:LNB] + RW'(LNB'(b) < addr[LNB-1:0]);
  endfunction

  state_e          state;
  logic [RW-1:0]   ctr;
  logic            rd_acc, wr_acc;
  logic [NB-1:0]   rlane_ok, wlane_ok;
  logic [NB-1:0]   wmask_bank, wdata_bank;
  logic [NB-1:0]   bank_rd, rd_lane;
  logic [RW-1:0]   rrow [NB];
  logic [RW-1:0]   wrow [NB];
  logic [ROWS-1:0] bank [NB];
  logic            vld_p1;
  logic [NB-1:0]   rdata_p1;

  // Accept accesses only while running; flush and reset drop same-cycle ops.
  always_comb begin
    rd_acc   = rd_en & ready & ~flush & ~reset;
    wr_acc   = wr_en & ready & ~flush & ~reset;
    rlane_ok = seg_lane_mask(raddr);
    wlane_ok = seg_lane_mask(waddr);
    for (int b = 0; b < NB; b++) begin
      rrow[b] = bank_row(raddr, b);
      wrow[b] = bank_row(waddr, b);
    end
  end

  gs232c_bitmap_rot #(.NB(NB)) u_rot_wmask (
    .din  (wmask & wlane_ok),
    .amt  (waddr[LNB-1:0]),
    .left (1'b1),
    .dout (wmask_bank)
  );

  gs232c_bitmap_rot #(.NB(NB)) u_rot_wdata (
    .din  (wdata),
    .amt  (waddr[LNB-1:0]),
    .left (1'b1),
    .dout (wdata_bank)
  );

  // Bank read with write-first bypass on a same-row masked write.
  always_comb begin
    bank_rd = '0;
    for (int b = 0; b < NB; b++) begin
      if (wr_acc && wmask_bank[b] && (wrow[b] == rrow[b])) bank_rd[b] = wdata_bank[b];
      else                                                 bank_rd[b] = bank[b][rrow[b]];
    end
  end

  gs232c_bitmap_rot #(.NB(NB)) u_rot_rdata (
    .din  (bank_rd),
    .amt  (raddr[LNB-1:0]),
    .left (1'b0),
    .dout (rd_lane)
  );

  // Clear sweep sequencing; ready is registered alongside the state.
  always_ff @(posedge clock) begin
    if (reset || flush) begin
      state <= ST_CLEAR;
      ctr   <= '0;
      ready <= 1'b0;
    end else if (state == ST_CLEAR) begin
      ctr <= ctr + 1'b1;
      if (ctr == RW'(ROWS - 1)) begin
        state <= ST_RUN;
        ready <= 1'b1;
      end
    end
  end

  // Bank storage: sweep zeroes one row per cycle, accepted writes update masked banks.
  always_ff @(posedge clock) begin
    if (state == ST_CLEAR) begin
      for (int b = 0; b < NB; b++) bank[b][ctr] <= 1'b0;
    end
    for (int b = 0; b < NB; b++) begin
      if (wr_acc && wmask_bank[b]) bank[b][wrow[b]] <= wdata_bank[b];
    end
  end

  // ---- stage p1: registered read data, held until the next accepted read ----
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1   <= 1'b0;
      rdata_p1 <= '0;
    end else begin
      vld_p1 <= rd_acc;
      if (rd_acc) rdata_p1 <= rd_lane & rlane_ok;
    end
  end

  assign rvalid = vld_p1;
  assign rdata  = rdata_p1;

endmodule

// File: tb/tb_gs232c_btb_bitmap_banked.sv
// Self-checking bench for gs232c_btb_bitmap_banked against a flat bit-array model.
module tb_gs232c_btb_bitmap_banked;

  localparam int AW    = 10;
  localparam int NB    = 4;
  localparam int SEG_W = 4;
  localparam int ROWS  = 256;
  localparam int NBITS = 1 << AW;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          flush = 1'b0;
  logic          ready;
  logic          rd_en = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic          rvalid;
  logic [NB-1:0] rdata;
  logic          wr_en = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [NB-1:0] wmask = '0;
  logic [NB-1:0] wdata = '0;

  int total = 0;
  int bad   = 0;
  bit mem [NBITS];
  logic [NB-1:0] exp_rdata = '0;

  gs232c_btb_bitmap_banked dut (
    .clock  (clock),
    .reset  (reset),
    .flush  (flush),
    .ready  (ready),
    .rd_en  (rd_en),
    .raddr  (raddr),
    .rvalid (rvalid),
    .rdata  (rdata),
    .wr_en  (wr_en),
    .waddr  (waddr),
    .wmask  (wmask),
    .wdata  (wdata)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  function automatic bit same_seg(input int a, input int i);
    return ((a + i) >> SEG_W) == (a >> SEG_W);
  endfunction

  function automatic logic [NB-1:0] model_read(input int a);
    logic [NB-1:0] r;
    r = '0;
    for (int i = 0; i < NB; i++) if (same_seg(a, i)) r[i] = mem[a + i];
    return r;
  endfunction

  task automatic model_write(input int a, input logic [NB-1:0] m, input logic [NB-1:0] d);
    for (int i = 0; i < NB; i++) if (m[i] && same_seg(a, i)) mem[a + i] = d[i];
  endtask

  task automatic model_clear();
    for (int i = 0; i < NBITS; i++) mem[i] = 1'b0;
  endtask

  // One cycle of traffic; model applies the write before the read (write-first).
  task automatic do_op(input bit r, input int ra, input bit w, input int wa,
                       input logic [NB-1:0] m, input logic [NB-1:0] d);
    rd_en = r; raddr = AW'(ra);
    wr_en = w; waddr = AW'(wa); wmask = m; wdata = d;
    if (w) model_write(wa, m, d);
    if (r) exp_rdata = model_read(ra);
    step();
    rd_en = 1'b0; wr_en = 1'b0;
  endtask

  // Walk a clear sweep that began on the previous edge, optionally with traffic that must be ignored.
  task automatic wait_sweep(input string tag, input bit busy);
    bit early;
    early = 1'b0;
    for (int k = 1; k <= ROWS; k++) begin
      if (busy) begin
        rd_en = 1'b1; raddr = AW'($urandom);
        wr_en = 1'b1; waddr = AW'($urandom); wmask = '1; wdata = '1;
      end
      step();
      if (k < ROWS && (ready !== 1'b0 || rvalid !== 1'b0)) early = 1'b1;
    end
    rd_en = 1'b0; wr_en = 1'b0;
    total++;
    if (early) begin
      bad++;
      $display("FAIL %s_sweep_quiet: ready/rvalid rose before cycle %0d, required 0", tag, ROWS);
    end
    total++;
    if (ready !== 1'b1) begin
      bad++;
      $display("FAIL %s_ready_at_%0d: got %b required 1", tag, ROWS, ready);
    end
    total++;
    if (rvalid !== 1'b0) begin
      bad++;
      $display("FAIL %s_rvalid_in_clear: got %b required 0", tag, rvalid);
    end
    model_clear();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    step();
    total++;
    if (ready !== 1'b0 || rvalid !== 1'b0 || rdata !== 4'b0000) begin
      bad++;
      $display("FAIL reset_values: ready=%b rvalid=%b rdata=%b required 0 0 0000", ready, rvalid, rdata);
    end
    reset = 1'b0;
    wait_sweep("reset", 1'b1);
    do_op(1'b1, 'h000, 1'b0, 0, '0, '0);
    total++;
    if (rvalid !== 1'b1 || rdata !== 4'b0000) begin
      bad++;
      $display("FAIL reset_read0: rvalid=%b rdata=%b required 1 0000", rvalid, rdata);
    end
  endtask

  task automatic test_windows();
    do_op(1'b0, 0, 1'b1, 'h005, 4'hF, 4'b1011);
    do_op(1'b1, 'h005, 1'b0, 0, '0, '0);
    total++;
    if (rvalid !== 1'b1 || rdata !== 4'b1011) begin
      bad++;
      $display("FAIL read_005: rvalid=%b rdata=%b required 1 1011", rvalid, rdata);
    end
    do_op(1'b1, 'h004, 1'b0, 0, '0, '0);
    total++;
    if (rdata !== 4'b0110) begin
      bad++;
      $display("FAIL read_004: got %b required 0110", rdata);
    end
    do_op(1'b0, 0, 1'b1, 'h00E, 4'hF, 4'hF);
    total++;
    if (rvalid !== 1'b0 || rdata !== 4'b0110) begin
      bad++;
      $display("FAIL idle_hold: rvalid=%b rdata=%b required 0 0110", rvalid, rdata);
    end
    do_op(1'b1, 'h00E, 1'b0, 0, '0, '0);
    total++;
    if (rdata !== 4'b0011) begin
      bad++;
      $display("FAIL seg_end_00E: got %b required 0011", rdata);
    end
    do_op(1'b1, 'h010, 1'b0, 0, '0, '0);
    total++;
    if (rdata !== 4'b0000) begin
      bad++;
      $display("FAIL seg_next_010: got %b required 0000", rdata);
    end
  endtask

  task automatic test_bypass();
    do_op(1'b0, 0, 1'b1, 'h020, 4'hF, 4'b1010);
    do_op(1'b1, 'h020, 1'b1, 'h020, 4'b0101, 4'b0101);
    total++;
    if (rvalid !== 1'b1 || rdata !== 4'b1111) begin
      bad++;
      $display("FAIL bypass_020: rvalid=%b rdata=%b required 1 1111", rvalid, rdata);
    end
    do_op(1'b1, 'h043, 1'b1, 'h041, 4'b1110, 4'b0110);
    total++;
    if (rdata !== exp_rdata) begin
      bad++;
      $display("FAIL bypass_unaligned: got %b required %b", rdata, exp_rdata);
    end
  endtask

  task automatic test_back_to_back();
    do_op(1'b0, 0, 1'b1, 'h101, 4'hF, 4'b1001);
    do_op(1'b1, 'h101, 1'b1, 'h105, 4'b0011, 4'b0001);
    total++;
    if (rdata !== 4'b1001) begin
      bad++;
      $display("FAIL b2b_first: got %b required 1001", rdata);
    end
    do_op(1'b1, 'h103, 1'b0, 0, '0, '0);
    total++;
    if (rvalid !== 1'b1 || rdata !== model_read('h103)) begin
      bad++;
      $display("FAIL b2b_second: rvalid=%b rdata=%b required 1 %b", rvalid, rdata, model_read('h103));
    end
  endtask

  task automatic test_random();
    bit r, w;
    int ra, wa;
    bit exp_v;
    for (int n = 0; n < 400; n++) begin
      r  = 1'($urandom_range(0, 1));
      w  = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 1) != 0) ? int'($urandom_range(0, 47)) : int'($urandom_range(0, NBITS - 1));
      wa = ($urandom_range(0, 2) == 0) ? ra : int'($urandom_range(0, 47));
      exp_v = r;
      do_op(r, ra, w, wa, NB'($urandom), NB'($urandom));
      total++;
      if (rvalid !== exp_v || rdata !== exp_rdata) begin
        bad++;
        $display("FAIL random_%0d: rvalid=%b rdata=%b required %b %b", n, rvalid, rdata, exp_v, exp_rdata);
      end
    end
  endtask

  task automatic test_flush();
    bit early;
    for (int a = 0; a < NBITS; a += NB) do_op(1'b0, 0, 1'b1, a, 4'hF, 4'hF);
    do_op(1'b1, 'h3FE, 1'b0, 0, '0, '0);
    total++;
    if (rdata !== 4'b0011) begin
      bad++;
      $display("FAIL fill_read_3FE: got %b required 0011", rdata);
    end
    flush = 1'b1;
    do_op(1'b1, 'h000, 1'b1, 'h000, 4'hF, 4'h0);
    flush = 1'b0;
    total++;
    if (rvalid !== 1'b0 || ready !== 1'b0) begin
      bad++;
      $display("FAIL flush_drop: rvalid=%b ready=%b required 0 0", rvalid, ready);
    end
    early = 1'b0;
    for (int k = 1; k < 100; k++) begin
      step();
      if (ready !== 1'b0) early = 1'b1;
    end
    total++;
    if (early) begin
      bad++;
      $display("FAIL flush_first_sweep: ready rose early, required 0");
    end
    flush = 1'b1;
    step();
    flush = 1'b0;
    wait_sweep("flush", 1'b1);
    for (int n = 0; n < 30; n++) begin
      do_op(1'b1, int'($urandom_range(0, NBITS - 1)), 1'b0, 0, '0, '0);
      total++;
      if (rvalid !== 1'b1 || rdata !== 4'b0000) begin
        bad++;
        $display("FAIL flush_cleared_%0d: rvalid=%b rdata=%b required 1 0000", n, rvalid, rdata);
      end
    end
  endtask

  initial begin
    model_clear();
    test_reset();
    test_windows();
    test_bypass();
    test_back_to_back();
    test_random();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
